// File: rtl/slow_counter_pkg.sv
// Shared constants for the slow event counter.
package slow_counter_pkg;

  // Tick source select encoding.
  localparam logic SRC_EXT = 1'b0;
  localparam logic SRC_INT = 1'b1;

  // Count direction encoding.
  localparam logic DIR_DN  = 1'b0;
  localparam logic DIR_UP  = 1'b1;

endpackage

// File: rtl/slow_tick_gen.sv
// Tick generator: synchronised rising-edge detect on 'slow' or an internal prescaler.
module slow_tick_gen
  import slow_counter_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned SYNC_STG  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 slow,
  input  logic                 src_sel,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 en,
  input  logic                 clr_i,
  output logic                 tick_o
);

  logic [SYNC_STG-1:0]  sync_q, sync_d;
  logic                 edge_q, edge_d;
  logic [DIV_WIDTH-1:0] pre_q, pre_d;
  logic                 sync_out;
  logic                 ext_tick;
  logic                 int_tick;

  assign sync_out = sync_q[SYNC_STG-1];
  assign ext_tick = sync_out & ~edge_q;
  // '>=' lets a prescaler stranded above a freshly lowered div tick at once.
  assign int_tick = (pre_q >= div);
  assign tick_o   = (src_sel == SRC_EXT) ? ext_tick : int_tick;

  // Next-state for sync chain, edge register and prescaler.
  always_comb begin
    sync_d = {sync_q[SYNC_STG-2:0], slow};
    edge_d = sync_out;
    pre_d  = pre_q;
    if (clr_i) begin
      pre_d = '0;
    end else if (en && (src_sel == SRC_INT)) begin
      pre_d = int_tick ? '0 : pre_q + 1'b1;
    end
  end

  // Sync chain and edge register reset high so a 'slow' already high gives no tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      edge_q <= 1'b1;
      pre_q  <= '0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
      pre_q  <= pre_d;
    end
  end

endmodule

// File: rtl/slow_counter_gen.sv
// Modulo up/down counter of slow events with synchronous load and wrap pulse.
module slow_counter_gen
  import slow_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned SYNC_STG  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 slow,
  input  logic                 src_sel,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 en,
  input  logic                 up_dn,
  input  logic [WIDTH-1:0]     mod_max,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  output logic [WIDTH-1:0]     q,
  output logic                 wrap,
  output logic                 tick_o
);

  logic             tick;
  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             tick_o_q, tick_o_d;

  slow_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH),
    .SYNC_STG  (SYNC_STG)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .slow    (slow),
    .src_sel (src_sel),
    .div     (div),
    .en      (en),
    .clr_i   (load),
    .tick_o  (tick)
  );

  // Next count: load beats a tick, a tick beats hold.
  always_comb begin
    q_d      = q_q;
    wrap_d   = 1'b0;
    tick_o_d = tick & en;
    if (load) begin
      q_d = (load_val < mod_max) ? load_val : mod_max;
    end else if (en && tick) begin
      if (up_dn == DIR_UP) begin
        if (q_q >= mod_max) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q + 1'b1;
        end
      end else if (up_dn == DIR_DN) begin
        if (q_q == '0) begin
          q_d    = mod_max;
          wrap_d = 1'b1;
        end else if (q_q > mod_max) begin
          // Out of range after mod_max was lowered: clamp without wrapping.
          q_d = mod_max;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  // Counter, wrap and tick copy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q      <= '0;
      wrap_q   <= 1'b0;
      tick_o_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      wrap_q   <= wrap_d;
      tick_o_q <= tick_o_d;
    end
  end

  assign q      = q_q;
  assign wrap   = wrap_q;
  assign tick_o = tick_o_q;

endmodule

// File: tb/tb_slow_counter_gen.sv
// Self-checking bench for slow_counter_gen: directed scenarios plus randomized traffic
// against a cycle-level behavioural model.
module tb_slow_counter_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       slow = 1'b1;
  logic       src_sel = 1'b0;
  logic [7:0] div = 8'd0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic [3:0] mod_max = 4'd15;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] q;
  logic       wrap;
  logic       tick_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: count, pulses, prescaler phase, last three sampled 'slow' values.
  int m_q, m_wrap, m_tick, m_pre;
  logic h0, h1, h2;

  slow_counter_gen #(
    .WIDTH     (4),
    .DIV_WIDTH (8),
    .SYNC_STG  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .slow     (slow),
    .src_sel  (src_sel),
    .div      (div),
    .en       (en),
    .up_dn    (up_dn),
    .mod_max  (mod_max),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .wrap     (wrap),
    .tick_o   (tick_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_wrap = 0; m_tick = 0; m_pre = 0;
    h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
  endtask

  task automatic check_all();
    check_eq("q", int'(q), m_q);
    check_eq("wrap", int'(wrap), m_wrap);
    check_eq("tick_o", int'(tick_o), m_tick);
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_q", int'(q), 0);
    check_eq("rst_wrap", int'(wrap), 0);
    check_eq("rst_tick_o", int'(tick_o), 0);
    #1;
    rst = 1'b0;
  endtask

  // One clock edge: predict from current inputs, advance, compare at edge+1.
  task automatic step();
    logic ext_t, int_t, t, s;
    int nq, nw, np;
    // A slow rise is seen two samples after it is captured.
    ext_t = h1 && !h2;
    int_t = (m_pre >= int'(div));
    t     = src_sel ? int_t : ext_t;
    s     = slow;
    nq = m_q; nw = 0; np = m_pre;
    if (load) begin
      nq = (load_val < mod_max) ? int'(load_val) : int'(mod_max);
      np = 0;
    end else begin
      if (en && t) begin
        if (up_dn) begin
          if (m_q >= int'(mod_max)) begin nq = 0; nw = 1; end
          else nq = m_q + 1;
        end else begin
          if (m_q == 0) begin nq = int'(mod_max); nw = 1; end
          else if (m_q > int'(mod_max)) nq = int'(mod_max);
          else nq = m_q - 1;
        end
      end
      if (en && src_sel) np = int_t ? 0 : m_pre + 1;
    end
    @(posedge clk);
    #1;
    m_q = nq; m_wrap = nw; m_pre = np; m_tick = (t && en) ? 1 : 0;
    h2 = h1; h1 = h0; h0 = s;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;

    // 1: slow high across reset release gives nothing; fresh rise lands 3 edges later.
    slow = 1'b1; src_sel = 1'b0; en = 1'b1; up_dn = 1'b1; mod_max = 4'd15;
    do_reset();
    steps(5);
    check_eq("t1_no_tick", int'(q), 0);
    slow = 1'b0;
    steps(3);
    slow = 1'b1;
    steps(2);
    check_eq("t1_lat2", int'(q), 0);
    step();
    check_eq("t1_lat3", int'(q), 1);
    steps(4);

    // 2: prescaler div=2, up to 5, wrap pulse with q=0.
    src_sel = 1'b1; div = 8'd2; mod_max = 4'd5; up_dn = 1'b1; en = 1'b1;
    do_reset();
    steps(17);
    check_eq("t2_q17", int'(q), 5);
    step();
    check_eq("t2_wrap_q", int'(q), 0);
    check_eq("t2_wrap", int'(wrap), 1);
    step();
    check_eq("t2_wrap_end", int'(wrap), 0);

    // 3: down from 0 wraps to mod_max, then decrements.
    div = 8'd0; up_dn = 1'b0; mod_max = 4'd9;
    do_reset();
    step();
    check_eq("t3_q", int'(q), 9);
    check_eq("t3_wrap", int'(wrap), 1);
    step();
    check_eq("t3_q2", int'(q), 8);
    check_eq("t3_wrap2", int'(wrap), 0);

    // 4: load clamps, drops coincident tick, restarts prescaler.
    up_dn = 1'b1; mod_max = 4'd7; load_val = 4'd12; load = 1'b1; div = 8'd0;
    step();
    check_eq("t4_load", int'(q), 7);
    load = 1'b0; div = 8'd3;
    steps(3);
    check_eq("t4_hold", int'(q), 7);
    step();
    check_eq("t4_tick", int'(q), 0);
    check_eq("t4_wrap", int'(wrap), 1);

    // 5: mod_max lowered below q.
    div = 8'd0; mod_max = 4'd15; load_val = 4'd10; load = 1'b1;
    step();
    load = 1'b0; mod_max = 4'd4; up_dn = 1'b1;
    step();
    check_eq("t5_up_q", int'(q), 0);
    check_eq("t5_up_wrap", int'(wrap), 1);
    mod_max = 4'd15; load = 1'b1;
    step();
    load = 1'b0; mod_max = 4'd4; up_dn = 1'b0;
    step();
    check_eq("t5_dn_q", int'(q), 4);
    check_eq("t5_dn_wrap", int'(wrap), 0);

    // 6: en=0 discards slow edges; prescaler frozen; async reset mid-count.
    mod_max = 4'd15; load_val = 4'd6; load = 1'b1; up_dn = 1'b1;
    step();
    load = 1'b0; en = 1'b0; src_sel = 1'b0; slow = 1'b0;
    for (int i = 0; i < 5; i++) begin
      steps(2);
      slow = 1'b1;
      steps(2);
      slow = 1'b0;
    end
    steps(3);
    check_eq("t6_hold", int'(q), 6);
    src_sel = 1'b1; div = 8'd4;
    steps(4);
    en = 1'b1;
    steps(4);
    check_eq("t6_pre_frozen", int'(q), 6);
    step();
    check_eq("t6_pre_tick", int'(q), 7);
    do_reset();
    check_eq("t6_after_rst", int'(q), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) slow = ~slow;
      if ($urandom_range(0, 49) == 0) src_sel = ~src_sel;
      if ($urandom_range(0, 29) == 0) div = 8'($urandom_range(0, 5));
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 39) == 0) mod_max = 4'($urandom_range(0, 15));
      load = ($urandom_range(0, 29) == 0);
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
